// File: rtl/bank_stream_pkg.sv
// Shared types for the bank stream reader: FSM states, lane width, skid FIFO depth.
// Pure declarations; no latency or backpressure of its own.
package bank_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_e;

    localparam int NUM_BANKS_DEF     = 16;
    localparam int D_WID_DEF         = 8;
    localparam int LANE_W            = NUM_BANKS_DEF * D_WID_DEF;
    localparam int STREAM_FIFO_DEPTH = 2;

    function automatic int lane_w(input int num_banks, input int d_wid);
        return num_banks * d_wid;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of {last, data} beats; a pushed beat is visible at the output the next cycle.
// Backpressure: the head entry is held stable until popped; the writer must never push while full.
module stream_skid_fifo
    import bank_stream_pkg::*;
#(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] in_payload,
    input  logic         pop,
    output logic [W-1:0] out_payload,
    output logic [1:0]   count
);

    logic [W-1:0] mem [STREAM_FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt_q;

    // One-bit pointers suffice because the depth is exactly two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
            for (int i = 0; i < STREAM_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_payload;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign out_payload = mem[rd_ptr];
    assign count       = cnt_q;

endmodule

// File: rtl/bank_stream_reader.sv
// Streams length beats of NUM_BANKS bytes from banked port B; first beat 3 cycles after start (STREAM_STRIDE_EN adds a stride port).
// Backpressure: reads issue only with skid-FIFO credit, so out_ready low loses nothing and stalls issue.
module bank_stream_reader
    import bank_stream_pkg::*;
#(
    parameter int NUM_BANKS = 16,
    parameter int A_WID     = 10,
    parameter int D_WID     = 8,
    parameter int LEN_WID   = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [A_WID-1:0]           base_addr,
    input  logic [LEN_WID-1:0]         length,
`ifdef STREAM_STRIDE_EN
    input  logic [A_WID-1:0]           stride,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       bank_en,
    output logic                       bank_we,
    output logic [A_WID-1:0]           bank_addr,
    input  logic [NUM_BANKS*D_WID-1:0] bank_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_BANKS*D_WID-1:0] out_data,
    output logic                       out_last
);

    localparam int LW = NUM_BANKS * D_WID;

    stream_state_e      state_q, state_d;
    logic [LEN_WID-1:0] len_q;
    logic [LEN_WID-1:0] issue_cnt;
    logic [A_WID-1:0]   addr_q;
    logic [A_WID-1:0]   addr_inc;
    logic               inflight;
    logic               inflight_last;
    logic               zero_done;
    logic [1:0]         fifo_cnt;
    logic               pop;
    logic               credit_ok;
    logic               issue;
    logic               final_issue;
    logic               accept;

`ifdef STREAM_STRIDE_EN
    logic [A_WID-1:0]   stride_q;
    assign addr_inc = stride_q;
`else
    assign addr_inc = A_WID'(1);
`endif

    assign accept      = (state_q == IDLE) && start;
    assign pop         = out_valid && out_ready;
    // A pop this cycle frees a slot by the time the new read lands.
    assign credit_ok   = ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2;
    assign issue       = (state_q == RUN) && (issue_cnt < len_q) && (credit_ok || pop);
    assign final_issue = issue && (issue_cnt == len_q - LEN_WID'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = zero_done;
        bank_en = issue;
        bank_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (final_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            issue_cnt     <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
`ifdef STREAM_STRIDE_EN
            stride_q      <= '0;
`endif
        end else begin
            zero_done     <= accept && (length == '0);
            inflight      <= issue;
            inflight_last <= final_issue;
            if (accept) begin
                len_q     <= length;
                addr_q    <= base_addr;
                issue_cnt <= '0;
`ifdef STREAM_STRIDE_EN
                stride_q  <= stride;
`endif
            end else if (issue) begin
                addr_q    <= addr_q + addr_inc;
                issue_cnt <= issue_cnt + LEN_WID'(1);
            end
        end
    end

    assign bank_addr = addr_q;
    assign out_valid = (fifo_cnt != 2'd0);

    stream_skid_fifo #(
        .W (LW + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (inflight),
        .in_payload  ({inflight_last, bank_rdata}),
        .pop         (pop),
        .out_payload ({out_last, out_data}),
        .count       (fifo_cnt)
    );

endmodule
